// File: rtl/alu_result_bcd.sv
// ALU result to packed-BCD converter: accepts {op_code, result} and resolves the sign and
// divide-by-zero encodings. It then runs an iterative double-dabble, one shift per clock.
module alu_result_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [WIDTH-1:0]      in_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  out_err
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [BW-1:0]    out_bcd_q, out_bcd_d;
    logic             out_neg_q, out_neg_d;
    logic             out_err_q, out_err_d;

    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_shift;
    logic [WIDTH-1:0] mag_shift;
    logic             load_neg;
    logic             load_err;
    logic [WIDTH-1:0] load_mag;

    // Per-digit add-3 correction that precedes each left shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
            always_comb begin
                if (bcd_q[4*gi +: 4] >= 4'd5) begin
                    bcd_adj[4*gi +: 4] = bcd_q[4*gi +: 4] + 4'd3;
                end else begin
                    bcd_adj[4*gi +: 4] = bcd_q[4*gi +: 4];
                end
            end
        end
    endgenerate

    assign bcd_shift = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
    assign mag_shift = {mag_q[WIDTH-2:0], 1'b0};

    assign load_neg = (in_op == OP_SUB) && in_result[WIDTH-1];
    assign load_err = (in_op == OP_DIV) && (in_result == {WIDTH{1'b1}});

    always_comb begin
        if (load_neg) begin
            load_mag = ~in_result + WIDTH'(1);
        end else if (load_err) begin
            load_mag = '0;
        end else begin
            load_mag = in_result;
        end
    end

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_bcd_d   = out_bcd_q;
        out_neg_d   = out_neg_q;
        out_err_d   = out_err_q;

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (in_valid) begin
                    mag_d   = load_mag;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    neg_d   = load_neg;
                    err_d   = load_err;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                mag_d = mag_shift;
                bcd_d = bcd_shift;
                cnt_d = cnt_q - CW'(1);
                // The final shift publishes straight into the output registers.
                if (cnt_q == CW'(1)) begin
                    out_bcd_d   = bcd_shift;
                    out_neg_d   = neg_q;
                    out_err_d   = err_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_neg_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_neg_q   <= out_neg_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_neg   = out_neg_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Directed-vector bench for alu_result_bcd: latency, sign/error decoding, backpressure, reset abort.
module tb_alu_result_bcd;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic        out_neg;
    logic        out_err;

    int errors_cnt;
    int checks_cnt;

    alu_result_bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_result (in_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_neg   (out_neg),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one result, time the conversion, hold off the output for hold_cycles, then handshake.
    task automatic run_txn(input string name, input logic [1:0] op, input logic [15:0] res,
                           input logic [19:0] exp_bcd, input logic exp_neg, input logic exp_err,
                           input int hold_cycles);
        int cyc;
        @(negedge clk);
        in_op     = op;
        in_result = res;
        in_valid  = 1'b1;
        check_eq({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({name, ".latency"}, 32'(cyc), 32'd16);
        check_eq({name, ".bcd"}, 32'(out_bcd), 32'(exp_bcd));
        check_eq({name, ".neg"}, 32'(out_neg), 32'(exp_neg));
        check_eq({name, ".err"}, 32'(out_err), 32'(exp_err));
        check_eq({name, ".in_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold_cycles; i++) begin
            in_valid  = 1'b1;
            in_op     = 2'b00;
            in_result = 16'h1111;
            @(posedge clk);
            #1;
            check_eq({name, ".hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({name, ".hold_bcd"}, 32'(out_bcd), 32'(exp_bcd));
            check_eq({name, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({name, ".hs_valid"}, 32'(out_valid), 32'd0);
        check_eq({name, ".hs_ready"}, 32'(in_ready), 32'd1);
        check_eq({name, ".hs_keep_bcd"}, 32'(out_bcd), 32'(exp_bcd));
        $display("txn %s op=%0d res=0x%04h -> bcd=%05h neg=%0d err=%0d lat=%0d",
                 name, op, res, out_bcd, out_neg, out_err, cyc);
    endtask

    initial begin
        errors_cnt = 0;
        checks_cnt = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_result = 16'h0000;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.in_ready", 32'(in_ready), 32'd0);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.out_bcd", 32'(out_bcd), 32'd0);
        check_eq("rst.out_neg", 32'(out_neg), 32'd0);
        check_eq("rst.out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_txn("add510",   2'b00, 16'd510,   20'h00510, 1'b0, 1'b0, 0);
        run_txn("sub_neg2", 2'b01, 16'hFFFE,  20'h00002, 1'b1, 1'b0, 0);
        run_txn("sub_neg255", 2'b01, 16'hFF01, 20'h00255, 1'b1, 1'b0, 0);
        run_txn("mul65025", 2'b10, 16'd65025, 20'h65025, 1'b0, 1'b0, 0);
        run_txn("add_max",  2'b00, 16'hFFFF,  20'h65535, 1'b0, 1'b0, 0);
        run_txn("mul_msb",  2'b10, 16'h8000,  20'h32768, 1'b0, 1'b0, 0);
        run_txn("div0",     2'b11, 16'hFFFF,  20'h00000, 1'b0, 1'b1, 0);
        run_txn("div17",    2'b11, 16'd17,    20'h00017, 1'b0, 1'b0, 0);
        run_txn("sub_zero", 2'b01, 16'h0000,  20'h00000, 1'b0, 1'b0, 0);
        run_txn("bp_sub",   2'b01, 16'hFF85,  20'h00123, 1'b1, 1'b0, 10);

        // The in_valid pulses offered during backpressure must not start a conversion.
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp.no_ghost_valid", 32'(out_valid), 32'd0);
        check_eq("bp.idle_ready", 32'(in_ready), 32'd1);
        run_txn("after_bp", 2'b00, 16'd42, 20'h00042, 1'b0, 1'b0, 0);

        // Abort a conversion on its 8th cycle, with in_valid asserted alongside reset.
        @(negedge clk);
        in_op     = 2'b01;
        in_result = 16'hFFFF;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_result = 16'd999;
        @(posedge clk);
        #1;
        check_eq("abort.out_valid", 32'(out_valid), 32'd0);
        check_eq("abort.out_bcd", 32'(out_bcd), 32'd0);
        check_eq("abort.out_neg", 32'(out_neg), 32'd0);
        check_eq("abort.in_ready_rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("abort.idle_ready", 32'(in_ready), 32'd1);
        $display("txn abort: rst mid-conversion -> out_valid=%0d out_bcd=%05h", out_valid, out_bcd);
        run_txn("post_rst1234", 2'b00, 16'd1234, 20'h01234, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
